// File: rtl/hyperspace_io_pkg.sv
// hyperspace_io_pkg
// Shared definitions for the HyperSpace pad bridge: the mprj_io pin
// assignment and the fixed pad output-enable pattern that goes with it.
// io_oeb is active-low, so a 0 marks a pad the bridge drives.
package hyperspace_io_pkg;

    localparam int IO_W         = 38;

    localparam int IN_DATA_MSB  = 37;
    localparam int IN_DATA_LSB  = 30;
    localparam int IN_LAST      = 29;
    localparam int IN_VALID     = 28;
    localparam int IN_READY     = 27;
    localparam int OUT_READY    = 26;
    localparam int OUT_VALID    = 25;
    localparam int OUT_LAST     = 24;
    localparam int OUT_DATA_MSB = 23;
    localparam int OUT_DATA_LSB = 8;

    // Pads [37:28] are inputs, 27 output, 26 input, [25:8] outputs, and
    // [7:0] are inputs left to the management SoC.
    localparam logic [IO_W-1:0] IO_OEB = {10'h3FF, 1'b0, 1'b1, 18'h0, 8'hFF};

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo
// Synchronous circular-buffer FIFO with occupancy count. The head entry is
// presented combinationally on pop_data whenever count is non-zero.
// Ports:
//   clock, RSTB       clock and synchronous active-high reset (flushes)
//   push, push_data   write an entry (ignored while full)
//   pop, pop_data     remove the head entry (ignored while empty)
//   count             number of stored entries, 0..DEPTH
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     RSTB,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    // Storage is not reset; a flush only clears pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hyperspace_io_bridge.sv
// hyperspace_io_bridge
// Pad-side stream bridge between mprj_io and the HyperSpace DSP core.
// Ports:
//   clock, RSTB              clock and synchronous active-high reset
//   io_in/io_out/io_oeb      Caravel pad values and active-low enables
//   m_data/m_valid/m_last    buffered input stream to the core (m_ready in)
//   s_data/s_valid/s_last    result stream from the core (s_ready out)
//   rx_frames, tx_frames     completed-frame counters, wrapping
// The input path pushes pin beats into a small FIFO; the output path is an
// output register backed by one skid register.
module hyperspace_io_bridge
    import hyperspace_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16
) (
    input  logic             clock,
    input  logic             RSTB,
    input  logic [37:0]      io_in,
    output logic [37:0]      io_out,
    output logic [37:0]      io_oeb,
    output logic [IN_W-1:0]  m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    input  logic [OUT_W-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [15:0]      rx_frames,
    output logic [15:0]      tx_frames
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_ready_q;
    logic             push;
    logic             pop;
    logic [IN_W:0]    push_data;
    logic [IN_W:0]    head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;

    logic             out_valid_q, out_valid_n;
    logic             out_last_q,  out_last_n;
    logic [OUT_W-1:0] out_data_q,  out_data_n;
    logic             skid_valid_q, skid_valid_n;
    logic             skid_last_q,  skid_last_n;
    logic [OUT_W-1:0] skid_data_q,  skid_data_n;
    logic             s_ready_q;
    logic             s_accept;
    logic             pin_xfer;
    logic             out_free;

    logic             unused_pins;

    assign io_oeb      = IO_OEB;
    assign unused_pins = ^{io_in[IN_READY], io_in[OUT_VALID:0]};

    // ---------------- input path ----------------

    // Pin data arrives bit-reversed: core bit i comes from pad 37-i.
    always_comb begin
        push_data       = '0;
        push_data[IN_W] = io_in[IN_LAST];
        for (int i = 0; i < IN_W; i++) begin
            push_data[i] = io_in[IN_DATA_MSB - i];
        end
    end

    assign push       = io_in[IN_VALID] && in_ready_q;
    assign m_valid    = (fifo_count != '0);
    assign pop        = m_valid && m_ready;
    assign m_data     = head[IN_W-1:0];
    assign m_last     = head[IN_W];
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    stream_fifo #(
        .WIDTH (IN_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clock     (clock),
        .RSTB      (RSTB),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    // Ready looks at the post-edge occupancy, so it can never admit a beat
    // the FIFO has no room for.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            in_ready_q <= 1'b0;
            rx_frames  <= '0;
        end else begin
            in_ready_q <= (count_next < CNT_W'(FIFO_DEPTH));
            if (push && io_in[IN_LAST]) begin
                rx_frames <= rx_frames + 16'd1;
            end
        end
    end

    // ---------------- output path ----------------

    assign s_ready  = s_ready_q;
    assign s_accept = s_valid && s_ready_q;
    assign pin_xfer = out_valid_q && io_in[OUT_READY];
    assign out_free = !out_valid_q || pin_xfer;

    // The output register refills from skid first to keep order; a core
    // beat only lands in skid when the output register is stuck. Skid can
    // never be full while s_ready is high, so no beat is lost.
    always_comb begin
        out_valid_n  = out_valid_q;
        out_last_n   = out_last_q;
        out_data_n   = out_data_q;
        skid_valid_n = skid_valid_q;
        skid_last_n  = skid_last_q;
        skid_data_n  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_last_n   = skid_last_q;
                out_data_n   = skid_data_q;
                skid_valid_n = 1'b0;
            end else begin
                out_valid_n = s_accept;
                if (s_accept) begin
                    out_last_n = s_last;
                    out_data_n = s_data;
                end
            end
        end else if (s_accept) begin
            skid_valid_n = 1'b1;
            skid_last_n  = s_last;
            skid_data_n  = s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (RSTB) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
            tx_frames    <= '0;
        end else begin
            out_valid_q  <= out_valid_n;
            out_last_q   <= out_last_n;
            out_data_q   <= out_data_n;
            skid_valid_q <= skid_valid_n;
            skid_last_q  <= skid_last_n;
            skid_data_q  <= skid_data_n;
            s_ready_q    <= !skid_valid_n;
            if (pin_xfer && out_last_q) begin
                tx_frames <= tx_frames + 16'd1;
            end
        end
    end

    // ---------------- pad outputs ----------------

    always_comb begin
        io_out                              = '0;
        io_out[IN_READY]                    = in_ready_q;
        io_out[OUT_VALID]                   = out_valid_q;
        io_out[OUT_LAST]                    = out_last_q;
        io_out[OUT_DATA_MSB:OUT_DATA_LSB]   = out_data_q;
    end

endmodule

// File: tb/tb_hyperspace_io_bridge.sv
// tb_hyperspace_io_bridge
// Directed bench for hyperspace_io_bridge: a table of input-pin vectors with
// hand-computed core-side values, plus sequences for back-pressure, output
// stall, long frames and reset in mid-operation.
module tb_hyperspace_io_bridge;

    logic        clock;
    logic        RSTB;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] rx_frames;
    logic [15:0] tx_frames;

    logic [7:0]  pin_data;
    logic        pin_last;
    logic        pin_valid;
    logic        pin_out_ready;

    int n_vectors;
    int n_miscompares;

    localparam logic [37:0] EXP_OEB = 38'h3FF40000FF;

    // Unused pads carry junk so the bridge is seen to ignore them.
    assign io_in = {pin_data, pin_last, pin_valid, 1'b1, pin_out_ready, 18'h2AAAA, 8'hA5};

    hyperspace_io_bridge #(
        .FIFO_DEPTH (4),
        .IN_W       (8),
        .OUT_W      (16)
    ) dut (
        .clock     (clock),
        .RSTB      (RSTB),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .rx_frames (rx_frames),
        .tx_frames (tx_frames)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pins;
        logic       last;
        logic [7:0] exp_data;
    } in_vec_t;

    // Advance one clock; outputs are then observed and inputs changed 1ns
    // after the active edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset(input int cycles);
        RSTB = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus();
        end
        RSTB = 1'b0;
    endtask

    initial begin
        in_vec_t     vecs[8];
        logic [7:0]  bp_pins[6];
        logic [15:0] stall_exp[3];
        int          idx;
        int          got;
        int          in_sent, out_sent, out_got, cycles;
        int          last_errs, data_errs, stale_m, stale_o;
        logic        in_acc, s_acc;

        vecs[0] = '{pins: 8'h01, last: 1'b0, exp_data: 8'h80};
        vecs[1] = '{pins: 8'hF0, last: 1'b0, exp_data: 8'h0F};
        vecs[2] = '{pins: 8'hA5, last: 1'b0, exp_data: 8'hA5};
        vecs[3] = '{pins: 8'h12, last: 1'b0, exp_data: 8'h48};
        vecs[4] = '{pins: 8'h36, last: 1'b1, exp_data: 8'h6C};
        vecs[5] = '{pins: 8'h80, last: 1'b0, exp_data: 8'h01};
        vecs[6] = '{pins: 8'hC8, last: 1'b1, exp_data: 8'h13};
        vecs[7] = '{pins: 8'h7E, last: 1'b0, exp_data: 8'h7E};

        // Pin patterns whose reversal gives core values 01..06.
        bp_pins[0] = 8'h80; bp_pins[1] = 8'h40; bp_pins[2] = 8'hC0;
        bp_pins[3] = 8'h20; bp_pins[4] = 8'hA0; bp_pins[5] = 8'h60;

        stall_exp[0] = 16'h1234; stall_exp[1] = 16'h5678; stall_exp[2] = 16'h9ABC;

        n_vectors     = 0;
        n_miscompares = 0;
        pin_data      = 8'h00;
        pin_last      = 1'b0;
        pin_valid     = 1'b0;
        pin_out_ready = 1'b0;
        m_ready       = 1'b0;
        s_data        = 16'h0;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        RSTB          = 1'b1;

        // ---- reset ----
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("rst_io_out_27_8", 64'(io_out[27:8]), 64'h0);
            checkOutput("rst_m_valid", 64'(m_valid), 64'h0);
            checkOutput("rst_s_ready", 64'(s_ready), 64'h0);
            checkOutput("rst_rx_frames", 64'(rx_frames), 64'h0);
            checkOutput("rst_tx_frames", 64'(tx_frames), 64'h0);
            checkOutput("rst_io_oeb", 64'(io_oeb), 64'(EXP_OEB));
        end
        RSTB = 1'b0;
        applyStimulus();
        checkOutput("post_rst_in_ready", 64'(io_out[27]), 64'h1);
        checkOutput("post_rst_s_ready", 64'(s_ready), 64'h1);
        checkOutput("io_out_mgmt_bits", 64'(io_out[7:0]), 64'h0);

        // ---- table-driven input vectors (bit reversal, last) ----
        m_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            pin_data  = vecs[v].pins;
            pin_last  = vecs[v].last;
            pin_valid = 1'b1;
            applyStimulus();
            pin_valid = 1'b0;
            checkOutput($sformatf("vec%0d_m_valid", v), 64'(m_valid), 64'h1);
            checkOutput($sformatf("vec%0d_m_data", v), 64'(m_data), 64'(vecs[v].exp_data));
            checkOutput($sformatf("vec%0d_m_last", v), 64'(m_last), 64'(vecs[v].last));
            applyStimulus();
            checkOutput($sformatf("vec%0d_popped", v), 64'(m_valid), 64'h0);
        end
        pin_last = 1'b0;
        checkOutput("table_rx_frames", 64'(rx_frames), 64'd2);

        // ---- input back-pressure ----
        m_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            pin_valid = (idx < 6);
            pin_data  = bp_pins[idx < 6 ? idx : 5];
            in_acc    = pin_valid && io_out[27];
            applyStimulus();
            if (in_acc) idx++;
        end
        checkOutput("bp_accepted", 64'(idx), 64'd4);
        checkOutput("bp_in_ready_low", 64'(io_out[27]), 64'h0);
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            pin_valid = (idx < 6);
            pin_data  = bp_pins[idx < 6 ? idx : 5];
            in_acc    = pin_valid && io_out[27];
            if (m_valid) begin
                checkOutput($sformatf("bp_order_%0d", got), 64'(m_data), 64'(got + 1));
                got++;
            end
            applyStimulus();
            if (in_acc) idx++;
        end
        pin_valid = 1'b0;
        checkOutput("bp_beats_out", 64'(got), 64'd6);

        // ---- output stall ----
        pin_out_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        applyStimulus();
        checkOutput("stall_out_valid", 64'(io_out[25]), 64'h1);
        checkOutput("stall_first_data", 64'(io_out[23:8]), 64'h1234);
        s_data = 16'h5678;
        applyStimulus();
        checkOutput("stall_s_ready_low", 64'(s_ready), 64'h0);
        checkOutput("stall_hold_data", 64'(io_out[23:8]), 64'h1234);
        s_data = 16'h9ABC;
        applyStimulus();
        applyStimulus();
        checkOutput("stall_still_held", 64'(io_out[23:8]), 64'h1234);
        checkOutput("stall_s_ready_still_low", 64'(s_ready), 64'h0);
        pin_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_acc = s_valid && s_ready;
            checkOutput($sformatf("drain%0d_valid", k), 64'(io_out[25]), 64'h1);
            checkOutput($sformatf("drain%0d_data", k), 64'(io_out[23:8]), 64'(stall_exp[k]));
            applyStimulus();
            if (s_acc) s_valid = 1'b0;
        end
        checkOutput("drain_empty", 64'(io_out[25]), 64'h0);
        checkOutput("drain_s_valid_taken", 64'(s_valid), 64'h0);
        checkOutput("drain_tx_frames", 64'(tx_frames), 64'h0);

        // ---- long frames in both directions at full rate ----
        doReset(3);
        applyStimulus();
        m_ready = 1'b1;
        pin_out_ready = 1'b1;
        in_sent = 0; out_sent = 0; out_got = 0; cycles = 0;
        last_errs = 0; data_errs = 0;
        while (!(in_sent == 2048 && out_got == 1536 && !m_valid) && cycles < 3000) begin
            pin_valid = (in_sent < 2048);
            pin_data  = in_sent[7:0];
            pin_last  = (in_sent == 2047);
            s_valid   = (out_sent < 1536);
            s_data    = out_sent[15:0];
            s_last    = (out_sent == 1535);
            in_acc    = pin_valid && io_out[27];
            s_acc     = s_valid && s_ready;
            if (io_out[25]) begin
                if (io_out[24] !== (out_got == 1535)) last_errs++;
                if (io_out[23:8] !== out_got[15:0]) data_errs++;
                out_got++;
            end
            applyStimulus();
            if (in_acc) in_sent++;
            if (s_acc) out_sent++;
            cycles++;
        end
        pin_valid = 1'b0;
        pin_last  = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        checkOutput("frame_in_beats", 64'(in_sent), 64'd2048);
        checkOutput("frame_out_beats", 64'(out_got), 64'd1536);
        checkOutput("frame_rx_frames", 64'(rx_frames), 64'd1);
        checkOutput("frame_tx_frames", 64'(tx_frames), 64'd1);
        checkOutput("frame_last_flag_errs", 64'(last_errs), 64'd0);
        checkOutput("frame_data_errs", 64'(data_errs), 64'd0);
        checkOutput("frame_throughput", 64'(cycles <= 2055), 64'h1);

        // ---- reset mid-operation ----
        m_ready = 1'b0;
        pin_out_ready = 1'b0;
        pin_valid = 1'b1; pin_data = 8'h11;
        s_valid = 1'b1; s_data = 16'h1111;
        applyStimulus();
        pin_data = 8'h22; s_data = 16'h2222;
        applyStimulus();
        pin_data = 8'h33; s_valid = 1'b0;
        applyStimulus();
        pin_valid = 1'b0;
        checkOutput("mid_pre_m_valid", 64'(m_valid), 64'h1);
        checkOutput("mid_pre_skid_full", 64'(s_ready), 64'h0);
        RSTB = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_m_valid", 64'(m_valid), 64'h0);
        checkOutput("mid_rst_out_valid", 64'(io_out[25]), 64'h0);
        checkOutput("mid_rst_rx_frames", 64'(rx_frames), 64'h0);
        checkOutput("mid_rst_tx_frames", 64'(tx_frames), 64'h0);
        RSTB = 1'b0;
        m_ready = 1'b1;
        pin_out_ready = 1'b1;
        stale_m = 0; stale_o = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            if (m_valid !== 1'b0) stale_m++;
            if (io_out[25] !== 1'b0) stale_o++;
        end
        checkOutput("mid_no_stale_in", 64'(stale_m), 64'd0);
        checkOutput("mid_no_stale_out", 64'(stale_o), 64'd0);
        checkOutput("mid_s_ready_back", 64'(s_ready), 64'h1);
        checkOutput("final_io_oeb", 64'(io_oeb), 64'(EXP_OEB));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/hyperspace_io_bridge.md
# hyperspace_io_bridge

Pad-side stream bridge between the Caravel `mprj_io` pins and the HyperSpace DSP core inside the user project area. It receives the chip-level 8-bit input stream (valid/ready/last) from the pins and buffers it into an internal AXI-Stream master port. It transmits the core's 16-bit result stream (valid/ready/last) back out to the pins. It also drives `io_oeb` for every pad and counts completed frames in each direction.

## Interface
- `FIFO_DEPTH`, 4: input-path buffer entries; power of two, ≥2.
- `IN_W`, 8: input stream data width; fixed by the pin map.
- `OUT_W`, 16: output stream data width; fixed by the pin map.

- `clock`  in  1  system clock.
- `RSTB`  in  1  reset, synchronous, active-high.
- `io_in`  in  38  pad input values.
- `io_out`  out  38  pad output values.
- `io_oeb`  out  38  pad output enable, active-low.
- `m_data`  out  IN_W  input beat data to the core.
- `m_valid`  out  1  input beat valid.
- `m_last`  out  1  input beat is last of frame.
- `m_ready`  in  1  core accepts input beat.
- `s_data`  in  OUT_W  result beat from the core.
- `s_valid`  in  1  result beat valid.
- `s_last`  in  1  result beat is last of frame.
- `s_ready`  out  1  bridge accepts result beat.
- `rx_frames`  out  16  count of input beats accepted with last=1; wraps 0xFFFF→0.
- `tx_frames`  out  16  count of pin output beats transferred with last=1; wraps.

## Operation

**Pin map** (constant `io_oeb`):
- [37:30] in_data, bit-reversed: m-side bit i = `io_in[37-i]`.
- [29] in_last, in; [28] in_valid, in; [27] in_ready, out.
- [26] out_ready, in; [25] out_valid, out; [24] out_last, out; [23:8] out_data, out.
- [7:0] input, `io_out=0`; left to the management SoC.
- Unused `io_out` bits are 0.

**Input path:**
- Pins are sampled directly; the external source is synchronous to `clock`.
- Transfer occurs at an edge when `io_in[28]=1` and registered `in_ready_q=1`. `{last,data}` is written into the FIFO, which has 9-bit entries.
- `in_ready_q <= (count_next < FIFO_DEPTH)`. Overflow is impossible.
- `m_valid = (count!=0)`. `m_data`/`m_last` come from the head entry.
- Pop occurs on `m_valid && m_ready`. A simultaneous push and pop leaves the count unchanged.
- `rx_frames` increments on a push with last=1.

**Output path:**
- Output register plus one skid register.
- `s_ready` is registered: `s_ready = !skid_valid`.
- Pin transfer occurs at an edge when `out_valid_q && io_in[26]`.
- Advance rule: if the output register is empty or transferring, it loads from skid if skid is full, else from s_valid. Otherwise an accepted s beat goes to skid.
- `tx_frames` increments on a pin transfer with `out_last_q=1`.

## Timing
- Reset, while RSTB is high:
  - FIFO and skid are flushed.
  - `in_ready_q`, `out_valid_q`, `out_last_q`, `out_data_q`, `s_ready`, `m_valid`, `rx_frames`, `tx_frames` are 0.
  - `io_oeb` holds its constant value.
- First cycle after release: `in_ready_q=1`, `s_ready=1`.
- Reset mid-frame discards all buffered beats. There is no partial-frame recovery.
- Input latency: a beat accepted at edge e gives `m_valid=1` in the cycle after e. It can be popped at e+1.
- Output latency: an s beat accepted at edge e appears on the pins in the cycle after e.
- Full FIFO: `in_ready_q=0` starting the cycle after the edge that filled it. A pop while full raises it the next cycle.
- Output stall, case 1: `out_valid_q=1` and the pin out_ready is low. An accepted s beat goes to skid, and `s_ready` drops the next cycle.
- Output stall, case 2: when the pin out_ready returns, skid moves to the output register. `s_ready` rises the next cycle.
- Beats are never dropped, duplicated or reordered in either path.
- Sustained throughput is one beat per cycle in both paths.

## Structure
- Package `hyperspace_io_pkg`:
  - pin index constants (IN_DATA_MSB/LSB, IN_LAST, IN_VALID, IN_READY, OUT_READY, OUT_VALID, OUT_LAST, OUT_DATA_MSB/LSB);
  - the constant `io_oeb` vector.
- Sub-module `stream_fifo`: synchronous FIFO, parameterised width/depth, with count output. It is used for the input path.
- Output skid and counters are inline.

## Test plan
- Reset: RSTB high 3 cycles → `io_out[27:8]=0`, `m_valid=0`, counters 0; next cycle `io_out[27]=1`, `s_ready=1`; `io_oeb` matches the package constant throughout.
- Bit reversal: pins[37:30]=8'b0000_0001 (pin30=1), valid=1, `m_ready=1` → `m_data=8'h80` the cycle after.
- Input back-pressure: `m_ready=0`, offer beats 01..06 continuously → exactly 4 accepted, pin27 low after 4th; then `m_ready=1` → `m_data` 01,02,03,04,05,06 in order, none lost.
- Output stall: s beats 1234, 5678, 9ABC with pin26=0 → pins hold 1234, `s_ready=0` after 5678 is accepted; raise pin26 → 1234, 5678, 9ABC on consecutive cycles.
- Frames: 2048-beat input frame with last on beat 2048, and a 1536-beat output frame with last on beat 1536 → `rx_frames=1`, `tx_frames=1`; pin24 high only on beat 1536.
- Reset mid-operation: 3 beats in the FIFO and skid full, assert RSTB → next cycle `m_valid=0`, pin25=0, counters 0; no stale beat appears after release.
